// File: rtl/neopixel_decoder.sv
// ---------------------------------------------------------------------------
// neopixel_decoder
//
// Receives a WS2812-style one-wire stream and rebuilds the 24-bit pixel words.
// The block times each high pulse and decodes a long pulse as 1 and a short
// pulse as 0. It shifts the bits in MSB first. A long continuous low marks the
// end of a frame (latch). Glitches, stuck-high pulses and partial words at a
// latch are reported as errors.
//
// Ports
//   clock         system clock
//   reset         synchronous, active-high reset
//   one_wire      asynchronous serial input line
//   pixel_data    last decoded 24-bit word, first received bit in [23]
//   pixel_valid   1-cycle pulse: pixel_data / pixel_index just updated
//   pixel_index   0-based position of that pixel within the current frame
//   frame_done    1-cycle pulse when a latch gap ends a frame
//   frame_pixels  number of complete pixels in the frame that just ended
//   error         1-cycle pulse on any protocol error
//   error_count   saturating count of error pulses (sticks at 255)
// ---------------------------------------------------------------------------
module neopixel_decoder #(
    parameter int MIN_HIGH_CYCLES      = 8,
    parameter int BIT_THRESHOLD_CYCLES = 30,
    parameter int MAX_HIGH_CYCLES      = 60,
    parameter int LATCH_CYCLES         = 2500,
    parameter int PIX_CNT_W            = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 one_wire,
    output logic [23:0]          pixel_data,
    output logic                 pixel_valid,
    output logic [PIX_CNT_W-1:0] pixel_index,
    output logic                 frame_done,
    output logic [PIX_CNT_W-1:0] frame_pixels,
    output logic                 error,
    output logic [7:0]           error_count
);

    localparam int LOW_W  = $clog2(LATCH_CYCLES + 1);
    localparam int HIGH_W = $clog2(MAX_HIGH_CYCLES + 1);

    localparam logic [LOW_W-1:0]  LATCH_VAL  = LOW_W'(LATCH_CYCLES);
    localparam logic [HIGH_W-1:0] MIN_VAL    = HIGH_W'(MIN_HIGH_CYCLES);
    localparam logic [HIGH_W-1:0] THRESH_VAL = HIGH_W'(BIT_THRESHOLD_CYCLES);
    localparam logic [HIGH_W-1:0] MAX_VAL    = HIGH_W'(MAX_HIGH_CYCLES);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_LOW,
        ST_HIGH
    } state_t;

    // Input synchronizer plus a delayed copy for edge detection
    logic s1_q, s2_q, prev_q;
    logic rise, fall;

    state_t                 state_q, state_d;
    logic [LOW_W-1:0]       low_cnt_q, low_cnt_d;
    logic [HIGH_W-1:0]      high_cnt_q, high_cnt_d;
    logic [22:0]            word_q, word_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic                   bits_seen_q, bits_seen_d;
    logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;

    logic                   pixel_valid_q, pixel_valid_d;
    logic [23:0]            pixel_data_q, pixel_data_d;
    logic [PIX_CNT_W-1:0]   pixel_index_q, pixel_index_d;
    logic                   frame_done_q, frame_done_d;
    logic [PIX_CNT_W-1:0]   frame_pixels_q, frame_pixels_d;
    logic                   error_q, error_d;
    logic [7:0]             error_count_q, error_count_d;

    logic                   bit_val;

    assign rise = ~prev_q & s2_q;
    assign fall = prev_q & ~s2_q;

    // Next-state logic. Only 23 bits of the shift register are kept. The 24th bit
    // is merged straight into pixel_data when it arrives, so pixel_valid leaves
    // one cycle after the fall is seen.
    always_comb begin
        state_d        = state_q;
        low_cnt_d      = low_cnt_q;
        high_cnt_d     = high_cnt_q;
        word_d         = word_q;
        bit_cnt_d      = bit_cnt_q;
        bits_seen_d    = bits_seen_q;
        pix_cnt_d      = pix_cnt_q;
        pixel_valid_d  = 1'b0;
        pixel_data_d   = pixel_data_q;
        pixel_index_d  = pixel_index_q;
        frame_done_d   = 1'b0;
        frame_pixels_d = frame_pixels_q;
        error_d        = 1'b0;
        bit_val        = 1'b0;

        case (state_q)
            ST_SYNC: begin
                // Only a long quiet line proves we are between frames
                if (s2_q) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == LATCH_VAL) begin
                    state_d = ST_LOW;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end

            ST_LOW: begin
                if (low_cnt_q != LATCH_VAL) begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
                // Latch fires once per frame; the saturated counter alone
                // does not retrigger because bits_seen is cleared here.
                if ((low_cnt_q == LATCH_VAL) && bits_seen_q) begin
                    frame_done_d   = 1'b1;
                    frame_pixels_d = pix_cnt_q;
                    if (bit_cnt_q != 5'd0) begin
                        error_d = 1'b1;
                    end
                    bit_cnt_d   = 5'd0;
                    pix_cnt_d   = '0;
                    bits_seen_d = 1'b0;
                end
                if (rise) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = HIGH_W'(1);
                end
            end

            ST_HIGH: begin
                if (fall) begin
                    if (high_cnt_q < MIN_VAL) begin
                        error_d     = 1'b1;
                        state_d     = ST_SYNC;
                        low_cnt_d   = '0;
                        bit_cnt_d   = 5'd0;
                        pix_cnt_d   = '0;
                        bits_seen_d = 1'b0;
                    end else begin
                        bit_val     = (high_cnt_q >= THRESH_VAL);
                        bits_seen_d = 1'b1;
                        state_d     = ST_LOW;
                        // The cycle in which the fall is seen is already low
                        low_cnt_d   = LOW_W'(1);
                        if (bit_cnt_q == 5'd23) begin
                            pixel_valid_d = 1'b1;
                            pixel_data_d  = {word_q, bit_val};
                            pixel_index_d = pix_cnt_q;
                            if (pix_cnt_q != {PIX_CNT_W{1'b1}}) begin
                                pix_cnt_d = pix_cnt_q + 1'b1;
                            end
                            bit_cnt_d = 5'd0;
                        end else begin
                            word_d    = {word_q[21:0], bit_val};
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (high_cnt_q == MAX_VAL) begin
                    // This is the first high cycle past the maximum width
                    error_d     = 1'b1;
                    state_d     = ST_SYNC;
                    low_cnt_d   = '0;
                    bit_cnt_d   = 5'd0;
                    pix_cnt_d   = '0;
                    bits_seen_d = 1'b0;
                end else begin
                    high_cnt_d = high_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = ST_SYNC;
                low_cnt_d = '0;
            end
        endcase

        error_count_d = error_count_q;
        if (error_d && (error_count_q != 8'hFF)) begin
            error_count_d = error_count_q + 8'd1;
        end
    end

    // All state and registered outputs; reset takes priority over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            prev_q         <= 1'b0;
            state_q        <= ST_SYNC;
            low_cnt_q      <= '0;
            high_cnt_q     <= '0;
            word_q         <= '0;
            bit_cnt_q      <= 5'd0;
            bits_seen_q    <= 1'b0;
            pix_cnt_q      <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_data_q   <= '0;
            pixel_index_q  <= '0;
            frame_done_q   <= 1'b0;
            frame_pixels_q <= '0;
            error_q        <= 1'b0;
            error_count_q  <= 8'd0;
        end else begin
            s1_q           <= one_wire;
            s2_q           <= s1_q;
            prev_q         <= s2_q;
            state_q        <= state_d;
            low_cnt_q      <= low_cnt_d;
            high_cnt_q     <= high_cnt_d;
            word_q         <= word_d;
            bit_cnt_q      <= bit_cnt_d;
            bits_seen_q    <= bits_seen_d;
            pix_cnt_q      <= pix_cnt_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_data_q   <= pixel_data_d;
            pixel_index_q  <= pixel_index_d;
            frame_done_q   <= frame_done_d;
            frame_pixels_q <= frame_pixels_d;
            error_q        <= error_d;
            error_count_q  <= error_count_d;
        end
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign pixel_index  = pixel_index_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign error        = error_q;
    assign error_count  = error_count_q;

endmodule
